// File: rtl/toast_mem_arbiter.sv
// toast_mem_arbiter: arbitrates instruction fetch and data ports onto one memory bus.
// One transaction in flight at a time, with fetch starvation guard and response timeout.
module toast_mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 15,
    parameter int DM_BURST_MAX   = 2
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    input  logic                  dm_req_i,
    input  logic                  dm_we_i,
    input  logic [3:0]            dm_be_i,
    input  logic [ADDR_WIDTH-1:0] dm_addr_i,
    input  logic [DATA_WIDTH-1:0] dm_wdata_i,
    output logic                  dm_gnt_o,
    output logic                  dm_rvalid_o,
    output logic [DATA_WIDTH-1:0] dm_rdata_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  stall_o,
    output logic                  bus_err_o
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT_IF = 2'd1;
    localparam logic [1:0] WAIT_DM = 2'd2;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW = $clog2(DM_BURST_MAX + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [BW-1:0] B_MAX   = BW'(DM_BURST_MAX);

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [BW-1:0] burst_q, burst_d;
    logic          idle, waiting, sel_dm, sel_if, timeout, resp;

    assign idle    = state_q == IDLE;
    // Any non-IDLE code counts as waiting so a corrupted state still times out back to IDLE.
    assign waiting = !idle;
    assign sel_dm  = dm_req_i && !(if_req_i && burst_q == B_MAX);
    assign sel_if  = if_req_i && !sel_dm;
    assign timeout = waiting && !mem_rvalid_i && tcnt_q == TO_LAST;
    assign resp    = waiting && (mem_rvalid_i || timeout);

    assign mem_req_o   = idle && (if_req_i || dm_req_i);
    assign mem_we_o    = idle && sel_dm && dm_we_i;
    assign mem_be_o    = (idle && sel_dm) ? dm_be_i : 4'b0000;
    assign mem_addr_o  = !idle ? '0 : sel_dm ? dm_addr_i : sel_if ? if_addr_i : '0;
    assign mem_wdata_o = (idle && sel_dm) ? dm_wdata_i : '0;

    assign if_gnt_o    = idle && sel_if && mem_gnt_i;
    assign dm_gnt_o    = idle && sel_dm && mem_gnt_i;
    assign if_rvalid_o = state_q == WAIT_IF && resp;
    assign dm_rvalid_o = state_q == WAIT_DM && resp;
    assign if_rdata_o  = (if_rvalid_o && mem_rvalid_i) ? mem_rdata_i : '0;
    assign dm_rdata_o  = (dm_rvalid_o && mem_rvalid_i) ? mem_rdata_i : '0;
    assign bus_err_o   = timeout;
    assign stall_o     = idle ? (if_req_i || dm_req_i) : !resp;

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        burst_d = burst_q;
        if (if_gnt_o) begin
            state_d = WAIT_IF;
            tcnt_d  = '0;
            burst_d = '0;
        end else if (dm_gnt_o) begin
            state_d = WAIT_DM;
            tcnt_d  = '0;
            burst_d = !if_req_i ? '0 : (burst_q == B_MAX) ? burst_q : burst_q + 1'b1;
        end else if (resp) begin
            state_d = IDLE;
        end else if (waiting) begin
            tcnt_d = tcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= IDLE;
            tcnt_q  <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            burst_q <= burst_d;
        end
    end
endmodule

// File: tb/tb_toast_mem_arbiter.sv
// tb_toast_mem_arbiter: directed stimulus with a per-cycle reference model of the arbiter.
module tb_toast_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 15;
    localparam int BM = 2;

    logic          clk_i = 0, resetn_i = 0;
    logic          if_req_i = 0, dm_req_i = 0, dm_we_i = 0, mem_gnt_i = 0, mem_rvalid_i = 0;
    logic [AW-1:0] if_addr_i = '0, dm_addr_i = '0;
    logic [3:0]    dm_be_i = '0;
    logic [DW-1:0] dm_wdata_i = '0, mem_rdata_i = '0;
    logic          if_gnt_o, if_rvalid_o, dm_gnt_o, dm_rvalid_o;
    logic          mem_req_o, mem_we_o, stall_o, bus_err_o;
    logic [DW-1:0] if_rdata_o, dm_rdata_o, mem_wdata_o;
    logic [AW-1:0] mem_addr_o;
    logic [3:0]    mem_be_o;

    int n_chk = 0, n_fail = 0;
    // Model: current owner (0 none, 1 fetch, 2 data), cycles already waited,
    // and consecutive data grants taken while a fetch was waiting.
    int m_own = 0, m_waited = 0, m_run = 0;

    logic          e_mreq, e_we, e_ig, e_dg, e_iv, e_dv, e_err, e_stall, fin;
    logic [3:0]    e_be;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_ir, e_dr, rd;

    always #5 clk_i = ~clk_i;

    toast_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .DM_BURST_MAX(BM)) dut (
        .clk_i(clk_i), .resetn_i(resetn_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i), .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .stall_o(stall_o), .bus_err_o(bus_err_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick();
        if (dm_req_i && !(if_req_i && m_run == BM)) return 2;
        return if_req_i ? 1 : 0;
    endfunction

    task automatic nxt();
        @(posedge clk_i);
        #1;
    endtask

    always @(posedge clk_i or negedge resetn_i) begin
        int p;
        if (!resetn_i) begin
            m_own = 0;
            m_run = 0;
        end else if (m_own == 0) begin
            p = pick();
            if (mem_gnt_i && p != 0) begin
                m_own    = p;
                m_waited = 0;
                m_run    = (p == 2 && if_req_i) ? ((m_run < BM) ? m_run + 1 : BM) : 0;
            end
        end else if (mem_rvalid_i || m_waited + 1 == TO) begin
            m_own = 0;
        end else begin
            m_waited++;
        end
    end

    always @(negedge clk_i) begin
        int p;
        {e_mreq, e_we, e_ig, e_dg, e_iv, e_dv, e_err, e_stall} = '0;
        e_be = '0; e_addr = '0; e_wdata = '0; e_ir = '0; e_dr = '0;
        if (m_own == 0) begin
            p       = pick();
            e_mreq  = if_req_i | dm_req_i;
            e_stall = e_mreq;
            if (p == 2) begin
                e_we = dm_we_i; e_be = dm_be_i; e_addr = dm_addr_i; e_wdata = dm_wdata_i; e_dg = mem_gnt_i;
            end else if (p == 1) begin
                e_addr = if_addr_i; e_ig = mem_gnt_i;
            end
        end else begin
            e_err   = !mem_rvalid_i && (m_waited + 1 == TO);
            fin     = mem_rvalid_i || e_err;
            rd      = mem_rvalid_i ? mem_rdata_i : '0;
            e_stall = !fin;
            if (m_own == 1) begin e_iv = fin; e_ir = fin ? rd : '0; end
            else begin e_dv = fin; e_dr = fin ? rd : '0; end
        end
        chk("m_mem_req", mem_req_o, e_mreq);
        chk("m_mem_we", mem_we_o, e_we);
        chk("m_mem_be", mem_be_o, e_be);
        chk("m_mem_addr", mem_addr_o, e_addr);
        chk("m_mem_wdata", mem_wdata_o, e_wdata);
        chk("m_if_gnt", if_gnt_o, e_ig);
        chk("m_dm_gnt", dm_gnt_o, e_dg);
        chk("m_if_rvalid", if_rvalid_o, e_iv);
        chk("m_dm_rvalid", dm_rvalid_o, e_dv);
        chk("m_if_rdata", if_rdata_o, e_ir);
        chk("m_dm_rdata", dm_rdata_o, e_dr);
        chk("m_bus_err", bus_err_o, e_err);
        chk("m_stall", stall_o, e_stall);
    end

    initial begin
        int exp_dm[6] = '{1, 1, 0, 1, 1, 0};
        // Reset: quiet outputs, grant still passes through combinationally.
        @(negedge clk_i);
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_bus_err", bus_err_o, 0);
        nxt();
        if_req_i = 1; if_addr_i = 32'h40; mem_gnt_i = 1;
        @(negedge clk_i);
        chk("rst_if_gnt_pass", if_gnt_o, 1);
        chk("rst_addr_pass", mem_addr_o, 32'h40);
        nxt();
        if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h99;
        @(negedge clk_i);
        chk("rst_no_rvalid", if_rvalid_o, 0);
        nxt();
        mem_rvalid_i = 0; resetn_i = 1;
        nxt();
        // Single fetch.
        if_req_i = 1; if_addr_i = 32'h100; mem_gnt_i = 1;
        @(negedge clk_i);
        chk("fetch_gnt", if_gnt_o, 1);
        chk("fetch_addr", mem_addr_o, 32'h100);
        chk("fetch_we", mem_we_o, 0);
        nxt();
        if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h13;
        @(negedge clk_i);
        chk("fetch_rvalid", if_rvalid_o, 1);
        chk("fetch_rdata", if_rdata_o, 32'h13);
        chk("fetch_stall", stall_o, 0);
        nxt();
        mem_rvalid_i = 0;
        // Simultaneous requests: data wins first, fetch next.
        if_req_i = 1; dm_req_i = 1; dm_we_i = 1; dm_be_i = 4'b0011;
        dm_addr_i = 32'h200; if_addr_i = 32'h300; dm_wdata_i = 32'hdeadbeef; mem_gnt_i = 1;
        @(negedge clk_i);
        chk("sim_we", mem_we_o, 1);
        chk("sim_addr", mem_addr_o, 32'h200);
        chk("sim_be", mem_be_o, 4'b0011);
        chk("sim_dm_gnt", dm_gnt_o, 1);
        chk("sim_if_gnt", if_gnt_o, 0);
        nxt();
        dm_req_i = 0; dm_we_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h55;
        @(negedge clk_i);
        chk("sim_dm_ack", dm_rvalid_o, 1);
        chk("sim_if_rvalid0", if_rvalid_o, 0);
        nxt();
        mem_rvalid_i = 0; mem_gnt_i = 1;
        @(negedge clk_i);
        chk("sim_then_if", if_gnt_o, 1);
        nxt();
        mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h66;
        nxt();
        // Starvation guard: DM, DM, IF, DM, DM, IF.
        dm_req_i = 1; dm_addr_i = 32'h400;
        for (int i = 0; i < 6; i++) begin
            mem_gnt_i = 1; mem_rvalid_i = 0;
            @(negedge clk_i);
            chk("burst_dm_gnt", dm_gnt_o, exp_dm[i]);
            chk("burst_if_gnt", if_gnt_o, exp_dm[i] == 0);
            nxt();
            mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h1000 + i;
            @(negedge clk_i);
            chk("burst_rdata", exp_dm[i] ? dm_rdata_o : if_rdata_o, 32'h1000 + i);
            nxt();
        end
        dm_req_i = 0; mem_rvalid_i = 0;
        // No grant: stall held, then cancel; stray response in IDLE ignored.
        mem_gnt_i = 0;
        nxt();
        @(negedge clk_i);
        chk("nogrant_stall", stall_o, 1);
        chk("nogrant_if_gnt", if_gnt_o, 0);
        nxt();
        if_req_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h77;
        @(negedge clk_i);
        chk("idle_rsp_if", if_rvalid_o, 0);
        chk("idle_rsp_dm", dm_rvalid_o, 0);
        nxt();
        mem_rvalid_i = 0;
        // Timeout on a data read.
        dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h500; mem_gnt_i = 1;
        @(negedge clk_i);
        chk("to_gnt", dm_gnt_o, 1);
        nxt();
        dm_req_i = 0; mem_gnt_i = 0; mem_rdata_i = 32'hffffffff;
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk_i);
            chk("to_bus_err", bus_err_o, k == TO);
            chk("to_dm_rvalid", dm_rvalid_o, k == TO);
            chk("to_stall", stall_o, k != TO);
            if (k == TO) chk("to_rdata", dm_rdata_o, 0);
            nxt();
        end
        @(negedge clk_i);
        chk("to_err_once", bus_err_o, 0);
        chk("to_idle_stall", stall_o, 0);
        nxt();
        // Response in the timeout cycle wins over the error.
        dm_req_i = 1; mem_gnt_i = 1;
        nxt();
        dm_req_i = 0; mem_gnt_i = 0;
        for (int k = 1; k <= TO; k++) begin
            mem_rvalid_i = (k == TO); mem_rdata_i = 32'habc;
            @(negedge clk_i);
            if (k == TO) begin
                chk("tie_rvalid", dm_rvalid_o, 1);
                chk("tie_rdata", dm_rdata_o, 32'habc);
                chk("tie_no_err", bus_err_o, 0);
            end
            nxt();
        end
        mem_rvalid_i = 0;
        // Reset during WAIT_IF drops the late response.
        if_req_i = 1; if_addr_i = 32'h600; mem_gnt_i = 1;
        nxt();
        if_req_i = 0; mem_gnt_i = 0; resetn_i = 0;
        @(negedge clk_i);
        chk("mid_rst_stall", stall_o, 0);
        nxt();
        resetn_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h88;
        @(negedge clk_i);
        chk("mid_rst_drop", if_rvalid_o, 0);
        nxt();
        mem_rvalid_i = 0; if_req_i = 1; mem_gnt_i = 1;
        @(negedge clk_i);
        chk("mid_rst_new_gnt", if_gnt_o, 1);
        nxt();
        if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h21;
        @(negedge clk_i);
        chk("mid_rst_new_rsp", if_rdata_o, 32'h21);
        nxt();
        mem_rvalid_i = 0;
        nxt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/toast_mem_arbiter.md
TOAST_MEM_ARBITER -- requirements
Module: toast_mem_arbiter

Interface
REQ-001 Parameters SHALL be:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- TIMEOUT_CYCLES, 15, maximum wait-state cycles before bus error
- DM_BURST_MAX, 2, maximum consecutive data grants while fetch is pending
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low. Ports SHALL be:
- clk_i  in  1  clock, rising edge
- resetn_i  in  1  asynchronous active-low reset
- if_req_i  in  1  instruction fetch request
- if_addr_i  in  ADDR_WIDTH  fetch address
- if_gnt_o  out  1  fetch request accepted
- if_rvalid_o  out  1  fetch data valid
- if_rdata_o  out  DATA_WIDTH  fetch data
- dm_req_i  in  1  data request
- dm_we_i  in  1  1=write, 0=read
- dm_be_i  in  4  write byte enables
- dm_addr_i  in  ADDR_WIDTH  data address
- dm_wdata_i  in  DATA_WIDTH  write data
- dm_gnt_o  out  1  data request accepted
- dm_rvalid_o  out  1  data response (read data or write ack)
- dm_rdata_o  out  DATA_WIDTH  read data
- mem_req_o  out  1  shared memory request
- mem_we_o  out  1  shared memory write enable
- mem_be_o  out  4  shared memory byte enables
- mem_addr_o  out  ADDR_WIDTH  shared memory address
- mem_wdata_o  out  DATA_WIDTH  shared memory write data
- mem_gnt_i  in  1  memory accepts request
- mem_rvalid_i  in  1  memory response valid
- mem_rdata_i  in  DATA_WIDTH  memory response data
- stall_o  out  1  pipeline stall request
- bus_err_o  out  1  one-cycle timeout pulse

Function
REQ-003 FSM states SHALL be IDLE, WAIT_IF, WAIT_DM; at most one transaction is outstanding.
REQ-004 In IDLE, the owner SHALL be selected combinationally: DM if dm_req_i is high, unless if_req_i is high and the burst counter equals DM_BURST_MAX, in which case IF is selected; otherwise IF if if_req_i is high.
REQ-005 In IDLE, mem_req_o SHALL be if_req_i|dm_req_i, and mem_addr/we/be/wdata SHALL be driven from the selected owner; an IF selection drives we=0 and be=4'b0000.
REQ-006 The grant to the selected owner (if_gnt_o or dm_gnt_o) SHALL equal mem_gnt_i in IDLE and SHALL be 0 in all other states; the non-selected owner's grant SHALL be 0.
REQ-007 A grant in IDLE SHALL transition the FSM to WAIT_IF or WAIT_DM on the next edge; without a grant, the FSM SHALL stay in IDLE.
REQ-008 In WAIT_*, mem_req_o SHALL be 0; on mem_rvalid_i, the owner's rvalid SHALL be asserted combinationally for that cycle with rdata=mem_rdata_i, and the FSM SHALL return to IDLE.
REQ-009 The non-owner rvalid SHALL be 0 and its rdata SHALL be 0.
REQ-010 mem_rvalid_i in IDLE SHALL be ignored: no rvalid is forwarded.
REQ-011 The timeout counter SHALL clear on entering WAIT_* and increment each WAIT_* cycle without mem_rvalid_i.
- When it reaches TIMEOUT_CYCLES, the owner rvalid SHALL pulse with rdata=0, bus_err_o SHALL pulse for 1 cycle, and the FSM SHALL return to IDLE.
- mem_rvalid_i in that same cycle SHALL take precedence: normal response, no error.
REQ-012 The burst counter SHALL increment (saturating at DM_BURST_MAX) on a DM grant while if_req_i is high.
- It SHALL clear on any IF grant, and on a DM grant while if_req_i is low.
REQ-013 stall_o SHALL be:
- (if_req_i|dm_req_i) in IDLE;
- ~mem_rvalid_i in WAIT_* (including the timeout cycle, where stall_o=0).
REQ-014 Deasserting a request before its grant SHALL cancel it without side effects.
REQ-015 The minimum transaction latency SHALL be 2 cycles (grant edge, then response cycle).

Reset
REQ-016 A low resetn_i SHALL immediately force IDLE and clear the timeout and burst counters, including mid-transaction; a response arriving after reset SHALL be dropped per REQ-010.
REQ-017 During reset, all outputs SHALL be 0 except those that pass through combinationally from inputs per REQ-005 and REQ-006 (IDLE behaviour).

Verification
REQ-018 Single fetch: if_req_i=1, addr=0x100, mem_gnt_i=1 at cycle 0, mem_rvalid_i=1, rdata=0x00000013 at cycle 1 -> if_gnt_o=1 at cycle 0, if_rvalid_o=1 with 0x00000013 at cycle 1, stall_o=0 at cycle 1.
REQ-019 Simultaneous requests: if_req_i=dm_req_i=1, dm_we_i=1, be=4'b0011, addr=0x200 -> mem_we_o=1, mem_addr_o=0x200, dm_gnt_o=1, if_gnt_o=0; after the response, IF is granted.
REQ-020 Starvation guard: dm_req_i and if_req_i held high, with a 1-cycle response each time -> grant sequence DM, DM, IF, DM, DM, IF.
REQ-021 Timeout: DM read granted, mem_rvalid_i held low -> at the 15th WAIT cycle, dm_rvalid_o=1, dm_rdata_o=0, bus_err_o=1 for exactly 1 cycle, then IDLE.
REQ-022 Reset mid-transaction: resetn_i low during WAIT_IF, mem_rvalid_i=1 after release -> if_rvalid_o stays 0, and the FSM is in IDLE accepting a new request.
